// File: rtl/iq_tx_pkg.sv
// Shared definitions for the IQ transmit burst framer: sample format,
// preamble amplitudes and the one-hot framer state encoding.
package iq_tx_pkg;

    localparam int SAMPLE_W = 11;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t AMP_POS  = 11'sd8;
    localparam sample_t AMP_NEG  = -11'sd8;
    localparam sample_t AMP_ZERO = 11'sd0;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_PRE  = 4'b0010,
        ST_DATA = 4'b0100,
        ST_TAIL = 4'b1000
    } state_t;

    // Preamble alternates +A / -A on I, starting with +A on symbol 0.
    function automatic sample_t preamble_i(input logic odd_sym);
        sample_t val;
        if (odd_sym) begin
            val = AMP_NEG;
        end else begin
            val = AMP_POS;
        end
        return val;
    endfunction

endpackage

// File: rtl/sym_timer.sv
// Sample-within-symbol counter; runs only while enabled and flags the last
// sample of each symbol.
module sym_timer #(
    parameter int OSR = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    output logic [$clog2(OSR)-1:0]  sc,
    output logic                    tick
);

    localparam int SC_W = $clog2(OSR);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OSR - 1);
    localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);

    logic [SC_W-1:0] sc_q;
    logic [SC_W-1:0] sc_d;

    assign tick = run & (sc_q == SC_LAST);
    assign sc   = sc_q;

    // Next count: held at zero when stopped, wraps after the last sample.
    always_comb begin
        sc_d = sc_q;
        if (!run) begin
            sc_d = '0;
        end else if (tick) begin
            sc_d = '0;
        end else begin
            sc_d = sc_q + SC_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q <= '0;
        end else begin
            sc_q <= sc_d;
        end
    end

endmodule

// File: rtl/iq_tx_framer.sv
// Burst framer: preamble, mapper data with zero-order hold to OSR samples,
// guard tail of zero symbols, then a done pulse.
module iq_tx_framer
    import iq_tx_pkg::*;
#(
    parameter int OSR           = 8,
    parameter int PRE_LEN       = 16,
    parameter int GUARD_LEN     = 4,
    parameter int PRIME_TIMEOUT = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start,
    output logic                       sym_ce,
    input  logic signed [SAMPLE_W-1:0] in_xr,
    input  logic signed [SAMPLE_W-1:0] in_xi,
    input  logic                       in_valid,
    output logic signed [SAMPLE_W-1:0] out_i,
    output logic signed [SAMPLE_W-1:0] out_q,
    output logic                       out_valid,
    output logic                       sym_strobe,
    output logic                       busy,
    output logic                       done
);

    localparam int CNT_W = $clog2(PRE_LEN + GUARD_LEN + PRIME_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_LEN - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(PRIME_TIMEOUT - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               seen_q;
    logic               seen_d;
    sample_t            sym_i_q;
    sample_t            sym_i_d;
    sample_t            sym_q_q;
    sample_t            sym_q_d;
    logic               done_q;
    logic               done_d;
    logic               sym_ce_s;
    logic               run_s;
    logic               tick_s;
    logic [$clog2(OSR)-1:0] sc_s;
    sample_t            in_i_s;
    sample_t            in_q_s;

    assign run_s  = (state_q != ST_IDLE);
    // An invalid mapper slot becomes a zero symbol rather than stale data.
    assign in_i_s = in_valid ? in_xr : AMP_ZERO;
    assign in_q_s = in_valid ? in_xi : AMP_ZERO;

    sym_timer #(
        .OSR (OSR)
    ) u_sym_timer (
        .clk   (CLK),
        .rst_n (RST),
        .run   (run_s),
        .sc    (sc_s),
        .tick  (tick_s)
    );

    // Burst sequencing, symbol selection and mapper handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seen_d   = seen_q;
        sym_i_d  = sym_i_q;
        sym_q_d  = sym_q_q;
        done_d   = 1'b0;
        sym_ce_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                sym_i_d = AMP_ZERO;
                sym_q_d = AMP_ZERO;
                if (start) begin
                    state_d = ST_PRE;
                    seen_d  = 1'b0;
                    sym_i_d = preamble_i(1'b0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (tick_s && (cnt_q == PRE_LAST)) begin
                    // First mapper request; its answer arrives one symbol later.
                    sym_ce_s = 1'b1;
                    state_d  = ST_DATA;
                    cnt_d    = '0;
                    seen_d   = seen_q | in_valid;
                    sym_i_d  = in_i_s;
                    sym_q_d  = in_q_s;
                end else if (tick_s) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    sym_i_d = preamble_i(cnt_d[0]);
                    sym_q_d = AMP_ZERO;
                end else begin
                    state_d = ST_PRE;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    sym_ce_s = 1'b1;
                    seen_d   = seen_q | in_valid;
                    // cnt_q counts zero symbols already sent while nothing was seen.
                    if ((seen_q && !in_valid) || (!seen_q && (cnt_q >= TO_LAST))) begin
                        state_d = ST_TAIL;
                        cnt_d   = '0;
                        sym_i_d = AMP_ZERO;
                        sym_q_d = AMP_ZERO;
                    end else begin
                        sym_i_d = in_i_s;
                        sym_q_d = in_q_s;
                        if (cnt_q < TO_LAST) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_TAIL: begin
                sym_i_d = AMP_ZERO;
                sym_q_d = AMP_ZERO;
                if (tick_s && (cnt_q == GUARD_LAST)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (tick_s) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d = ST_TAIL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                seen_d  = 1'b0;
                sym_i_d = AMP_ZERO;
                sym_q_d = AMP_ZERO;
            end
        endcase
    end

    // State and held-symbol registers; reset aborts any burst in progress.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            sym_i_q <= AMP_ZERO;
            sym_q_q <= AMP_ZERO;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            sym_i_q <= sym_i_d;
            sym_q_q <= sym_q_d;
            done_q  <= done_d;
        end
    end

    assign out_i      = sym_i_q;
    assign out_q      = sym_q_q;
    assign busy       = run_s;
    assign out_valid  = run_s;
    assign sym_strobe = run_s & (sc_s == '0);
    assign sym_ce     = sym_ce_s;
    assign done       = done_q;

endmodule

// File: tb/tb_iq_tx_framer.sv
// Self-checking bench for iq_tx_framer: table of burst scenarios plus random
// mapper behaviour, each checked every cycle against a symbol-list model.
module tb_iq_tx_framer;

    localparam int OSR           = 8;
    localparam int PRE_LEN       = 16;
    localparam int GUARD_LEN     = 4;
    localparam int PRIME_TIMEOUT = 4;
    localparam int LIST          = 48;

    logic CLK;
    logic RST;
    logic clk_en;
    logic start;
    logic in_valid;
    logic sym_ce;
    logic out_valid;
    logic sym_strobe;
    logic busy;
    logic done;
    logic signed [10:0] in_xr;
    logic signed [10:0] in_xi;
    logic signed [10:0] out_i;
    logic signed [10:0] out_q;

    // Mapper script: what the mapper presents before sym_ce number k.
    logic               lv[LIST];
    logic signed [10:0] lx[LIST];
    logic signed [10:0] lq[LIST];

    int n_checks;
    int n_fail;

    typedef struct {
        int d;
        int n;
        int mode;
        int poke;
        int exp_ndata;
        int exp_done;
    } vec_t;

    vec_t vecs[7];

    iq_tx_framer #(
        .OSR           (OSR),
        .PRE_LEN       (PRE_LEN),
        .GUARD_LEN     (GUARD_LEN),
        .PRIME_TIMEOUT (PRIME_TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .sym_ce     (sym_ce),
        .in_xr      (in_xr),
        .in_xi      (in_xi),
        .in_valid   (in_valid),
        .out_i      (out_i),
        .out_q      (out_q),
        .out_valid  (out_valid),
        .sym_strobe (sym_strobe),
        .busy       (busy),
        .done       (done)
    );

    initial CLK = 1'b0;
    always #5 if (clk_en) CLK = ~CLK;

    function automatic logic [31:0] snap();
        return {5'd0, out_valid, sym_strobe, sym_ce, busy, done, out_i, out_q};
    endfunction

    task automatic check(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, c, got, exp);
        end
    endtask

    task automatic idle_check(input string name, input int ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge CLK);
            #1;
            check(name, c, snap(), 32'd0);
        end
    endtask

    task automatic reset_midway(input string name);
        #2 RST = 1'b0;
        #1 check(name, 0, snap(), 32'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        idle_check({name, "_idle"}, 10);
    endtask

    task automatic drive_mapper(input int j);
        in_valid = lv[j];
        in_xr    = lx[j];
        in_xi    = lq[j];
    endtask

    // One burst: d invalid slots, n valid slots, then invalid forever.
    task automatic run_burst(input string name, input int d, input int n, input int mode,
                             input int poke, input int exp_ndata, input int exp_done,
                             input int abort_c, input int chain);
        logic signed [10:0] es_i[$];
        logic signed [10:0] es_q[$];
        logic        seen;
        logic        prev_ce;
        logic        ce;
        logic [31:0] exp;
        int ndata, total, done_c, cyc_end, j, ce_cnt, done_at, p, s, ph;

        for (int k = 0; k < LIST; k++) begin
            lv[k] = (k >= d) && (k < d + n);
            lx[k] = 11'($urandom);
            lq[k] = 11'($urandom);
        end
        if (mode == 1) begin
            lx[0] = 11'sd8;
            lq[0] = 11'sd0;
            lx[1] = 11'sd0;
            lq[1] = -11'sd8;
        end

        // Expected symbol list from the framing rules.
        for (int k = 0; k < PRE_LEN; k++) begin
            es_i.push_back((k % 2 == 1) ? -11'sd8 : 11'sd8);
            es_q.push_back(11'sd0);
        end
        seen = lv[0];
        es_i.push_back(lv[0] ? lx[0] : 11'sd0);
        es_q.push_back(lv[0] ? lq[0] : 11'sd0);
        ndata = 1;
        for (int k = 1; k < LIST; k++) begin
            if ((seen && !lv[k]) || (!seen && (k >= PRIME_TIMEOUT))) break;
            es_i.push_back(lv[k] ? lx[k] : 11'sd0);
            es_q.push_back(lv[k] ? lq[k] : 11'sd0);
            seen  = seen | lv[k];
            ndata = ndata + 1;
        end
        for (int k = 0; k < GUARD_LEN; k++) begin
            es_i.push_back(11'sd0);
            es_q.push_back(11'sd0);
        end
        total   = PRE_LEN + ndata + GUARD_LEN;
        done_c  = total * OSR + 1;
        cyc_end = (chain != 0) ? done_c : done_c + 3;

        j       = 0;
        ce_cnt  = 0;
        done_at = 0;
        prev_ce = 1'b0;
        drive_mapper(0);
        start = 1'b1;
        for (int c = 1; c <= cyc_end; c++) begin
            @(posedge CLK);
            #1;
            start = 1'b0;
            if (prev_ce) begin
                if (j < LIST - 1) j++;
                drive_mapper(j);
            end
            if ((poke != 0) && ((c == 40) || (c == 140))) start = 1'b1;
            if ((chain != 0) && (c == done_c)) start = 1'b1;

            p = c - 1;
            if (p < total * OSR) begin
                s   = p / OSR;
                ph  = p % OSR;
                ce  = (ph == OSR - 1) && (s >= PRE_LEN - 1) && (s < PRE_LEN + ndata);
                exp = {5'd0, 1'b1, (ph == 0), ce, 1'b1, 1'b0, es_i[s], es_q[s]};
            end else if (p == total * OSR) begin
                exp = {5'd0, 5'b00001, 22'd0};
            end else begin
                exp = 32'd0;
            end
            check(name, c, snap(), exp);
            if (sym_ce) ce_cnt++;
            if (done && (done_at == 0)) done_at = c;
            prev_ce = sym_ce;

            if (c == abort_c) begin
                reset_midway({name, "_abort"});
                break;
            end
        end

        if (abort_c == 0) begin
            if (exp_ndata >= 0) check({name, "_sym_ce_count"}, done_at, 32'(ce_cnt), 32'(exp_ndata + 1));
            if (exp_done > 0) check({name, "_done_cycle"}, done_at, 32'(done_at), 32'(exp_done));
        end

        if (chain != 0) begin
            @(posedge CLK);
            #1;
            start = 1'b0;
            check({name, "_restart"}, done_c + 1, snap(),
                  {5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'sd8, 11'sd0});
            reset_midway({name, "_cleanup"});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk_en   = 1'b0;
        RST      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_xr    = 11'sd0;
        in_xi    = 11'sd0;

        //        d  n  mode poke ndata done
        vecs[0] = '{0, 0, 0, 0, 4, 193};
        vecs[1] = '{1, 6, 0, 0, 7, 217};
        vecs[2] = '{0, 3, 0, 0, 3, 185};
        vecs[3] = '{3, 2, 0, 0, 5, 201};
        vecs[4] = '{4, 2, 0, 0, 4, 193};
        vecs[5] = '{2, 1, 0, 1, 3, 185};
        vecs[6] = '{0, 2, 1, 0, 2, 177};

        // Reset with the clock stopped.
        #2 RST = 1'b0;
        #3 check("reset_noclk", 0, snap(), 32'd0);
        clk_en = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        idle_check("idle_after_reset", 20);

        for (int v = 0; v < 7; v++) begin
            run_burst($sformatf("vec%0d", v), vecs[v].d, vecs[v].n, vecs[v].mode,
                      vecs[v].poke, vecs[v].exp_ndata, vecs[v].exp_done, 0, 0);
        end

        // Start accepted in the done cycle.
        run_burst("chain", 0, 0, 0, 0, 4, 193, 0, 1);

        // Reset on DATA symbol 3, sample 5.
        run_burst("abort", 0, 0, 0, 0, -1, 0, 158, 0);

        for (int r = 0; r < 6; r++) begin
            run_burst($sformatf("rand%0d", r), int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                      0, 0, -1, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
